fpdec: RTL and testbench
========================

Name: fpdec

Overview:
- Floating-point-to-linear decoder: the inverse of the team's 12-bit linear-to-FP converter (fpcvt).
- Accepts a sign/exponent/significand triple (S, E[2:0], F[3:0]) and produces the 12-bit two's-complement value (-1)^S * F * 2^E.
- Multi-cycle iterative shifter with valid/ready handshakes on both sides.
- Sits downstream of fpcvt or any FP source, e.g. a DAC/display path or a round-trip checker.

Parameters:
- DW, 12, output width; must satisfy DW >= FW + 2^EW.
- EW, 3, exponent width.
- FW, 4, significand width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input triple valid.
- in_ready  out  1  block can accept a triple.
- s  in  1  sign.
- e  in  EW  exponent (shift count).
- f  in  FW  unsigned significand.
- out_valid  out  1  d holds a result.
- out_ready  in  1  consumer accepts the result.
- d  out  DW  two's-complement result.

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; in_ready=1; out_valid=0; d=0; internal acc/cnt/sign=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch sign<=s, cnt<=e, acc<={0,f} (zero-extended to DW), then go to SHIFT.
  - SHIFT: if cnt!=0, acc<=acc<<1 and cnt<=cnt-1. If cnt==0, d<=sign ? -acc : acc (DW-bit two's negate), out_valid<=1, go to DONE.
  - DONE: d and out_valid held stable. On out_ready, out_valid<=0 and go to IDLE.
- in_ready is combinational: (state==IDLE). No input is accepted in SHIFT or DONE; in_valid is ignored there.
- Latency: accept on edge k; out_valid high after edge k+E+1.
- Throughput: one result per E+3 cycles minimum (accept, E shifts, sign, handshake).
- Width: max magnitude 15*2^7=1920 fits DW=12 signed. No overflow or saturation logic.
- F=0: result 0 for any E. S=1 with F=0 gives 0x000; negative zero is never produced.
- d changes only on the SHIFT->DONE edge. It keeps its last value in IDLE.
- out_ready high while not in DONE: no effect.
- rst_n asserted in any state: immediate return to reset values; any in-flight conversion is discarded. First edge after release behaves as IDLE.

Optional Feature:
- Macro: FPDEC_FAST_EN.
- Defined: SHIFT state is removed. A combinational barrel shift plus negate registers d on the accept edge, so out_valid is high after edge k+1 for every E.
- Handshake and DONE behaviour are unchanged; cnt is not instantiated.
- Undefined: iterative behaviour above.
- Results are bit-identical in both builds.

Decomposition:
- Shared package fpdec_pkg: DW/EW/FW defaults, state enum (IDLE, SHIFT, DONE), localparam MAX_MAG=15<<7.
- Widths are shared with fpcvt so both blocks use one definition.
- Single module; no sub-module is natural. The shift/negate datapath is under 30 lines and stays inline.

Test Plan:
- Reset, then s=0,e=0,f=0 -> d=0x000; out_valid 1 cycle after accept; in_ready low until out_ready handshake.
- s=0,e=7,f=4'b1111 -> d=0x780 (1920); out_valid exactly 8 cycles after accept.
- s=1,e=7,f=4'b1111 -> d=0x880 (-1920). Then s=1,e=0,f=0 -> d=0x000.
- s=0,e=2,f=4'b1011 -> d=0x02C (44), latency 3. Then s=0,e=2,f=4'b1100 -> d=0x030.
- Backpressure: out_ready low for 5 cycles in DONE with in_valid high and new data -> d and out_valid stable, in_ready=0, new triple not captured. Drop out_ready after the handshake; the next accept converts the new triple.
- rst_n pulsed low mid-SHIFT (e=6) -> out_valid=0, d=0, in_ready=1 immediately. After release, s=0,e=1,f=4'b0011 -> d=0x006.
- Both tests run with and without FPDEC_FAST_EN. Under FPDEC_FAST_EN, all latencies are 1.

Source files
------------

// File: rtl/fpdec_pkg.sv
// fpdec shared definitions: widths common with fpcvt, FSM state encoding.
// Build option FPDEC_FAST_EN selects the single-cycle barrel-shift datapath.
package fpdec_pkg;

  localparam int FPDEC_DW = 12;
  localparam int FPDEC_EW = 3;
  localparam int FPDEC_FW = 4;
  localparam int MAX_MAG  = 15 << 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fpdec.sv
// FP triple (s, e, f) to DW-bit two's-complement decoder, valid/ready on both sides.
// FPDEC_FAST_EN: combinational barrel shift on accept instead of iterative shifting.
module fpdec
  import fpdec_pkg::*;
#(
  parameter int DW = FPDEC_DW,
  parameter int EW = FPDEC_EW,
  parameter int FW = FPDEC_FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          s,
  input  logic [EW-1:0] e,
  input  logic [FW-1:0] f,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] d
);

  state_t state;
  state_t state_nx;
  logic   accept;

  assign accept = in_valid && (state == IDLE);

`ifdef FPDEC_FAST_EN
  logic [DW-1:0] mag;

  assign mag = {{(DW-FW){1'b0}}, f} << e;

  // out_valid rises one edge after d is loaded so latency stays at one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept)
        d <= s ? -mag : mag;
      if ((state == DONE) && !out_valid)
        out_valid <= 1'b1;
      else if ((state == DONE) && out_ready)
        out_valid <= 1'b0;
    end
  end
`else
  logic [DW-1:0] acc;
  logic [EW-1:0] cnt;
  logic          sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      d         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      sign <= s;
      cnt  <= e;
      acc  <= {{(DW-FW){1'b0}}, f};
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        acc <= acc << 1;
        cnt <= cnt - 1'b1;
      end else begin
        d         <= sign ? -acc : acc;
        out_valid <= 1'b1;
      end
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef FPDEC_FAST_EN
          state_nx = DONE;
`else
          state_nx = SHIFT;
`endif
        end
      end
`ifndef FPDEC_FAST_EN
      SHIFT: begin
        if (cnt == '0)
          state_nx = DONE;
      end
`endif
      DONE: begin
        if (out_valid && out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

endmodule

// File: tb/tb_fpdec.sv
// Directed scoreboard bench for fpdec; expected values come from a magnitude/sign model.
// Works for both the iterative and the FPDEC_FAST_EN build.
module tb_fpdec;

`ifdef FPDEC_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d;

  int n_assert;
  int n_fail;

  logic [11:0] sb_d[$];
  int          sb_lat[$];
  logic [11:0] held_d;

  fpdec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .e        (e),
    .f        (f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] model(input logic sv,
                                        input logic [2:0] ev,
                                        input logic [3:0] fv);
    int m;
    m = int'(fv) * (1 << ev);
    if (sv) m = -m;
    return 12'(m);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic sv,
                      input logic [2:0] ev,
                      input logic [3:0] fv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    s = sv;
    e = ev;
    f = fv;
    sb_d.push_back(model(sv, ev, fv));
    sb_lat.push_back(FAST ? 1 : int'(ev) + 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int lat;
    logic [11:0] exp_d;
    int exp_lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    exp_d   = sb_d.pop_front();
    exp_lat = sb_lat.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_d"}, 32'(d), 32'(exp_d));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    held_d = exp_d;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_d_kept"}, 32'(d), 32'(held_d));
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s         = 1'b0;
    e         = '0;
    f         = '0;
    held_d    = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(1'b0, 3'd0, 4'd0);
    collect("zero");
    handshake("zero");

    send(1'b0, 3'd7, 4'hf);
    collect("max_pos");
    handshake("max_pos");

    send(1'b1, 3'd7, 4'hf);
    collect("max_neg");
    handshake("max_neg");

    send(1'b1, 3'd0, 4'd0);
    collect("neg_zero");
    handshake("neg_zero");

    send(1'b0, 3'd2, 4'b1011);
    collect("e2_f11");
    handshake("e2_f11");

    send(1'b0, 3'd2, 4'b1100);
    collect("e2_f12");
    handshake("e2_f12");

    // backpressure: new triple offered while the result is held
    send(1'b1, 3'd1, 4'd3);
    collect("bp");
    in_valid = 1'b1;
    s = 1'b0;
    e = 3'd7;
    f = 4'hf;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_d_stable", 32'(d), 32'(held_d));
    end
    in_valid = 1'b0;
    handshake("bp");

    send(1'b0, 3'd3, 4'd5);
    collect("after_bp");
    handshake("after_bp");

    // reset in the middle of a conversion
    in_valid = 1'b1;
    s = 1'b0;
    e = 3'd6;
    f = 4'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_d", 32'(d), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    held_d = '0;

    send(1'b0, 3'd1, 4'b0011);
    collect("post_rst");
    handshake("post_rst");

    check("sb_empty", 32'(sb_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
